// File: rtl/reservation_station.sv
// Operand-collecting reservation station: allocates the lowest free slot, snoops the
// result bus for missing operands and issues the lowest-index ready entry.
module reservation_station #(
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_OFFSET   = 0,
    parameter int RS_DEPTH    = 4,
    parameter int OP_WIDTH    = 32,
    parameter int CTRL_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   operation_valid,
    output logic                   operation_ready,
    input  logic [CTRL_WIDTH-1:0]  operation_ctrl,
    output logic [RS_ID_WIDTH-1:0] operation_id,
    input  logic                   op_a_valid,
    input  logic                   op_b_valid,
    input  logic [OP_WIDTH-1:0]    op_a_value,
    input  logic [OP_WIDTH-1:0]    op_b_value,
    input  logic [RS_ID_WIDTH-1:0] op_a_tag,
    input  logic [RS_ID_WIDTH-1:0] op_b_tag,
    input  logic                   result_valid,
    input  logic [RS_ID_WIDTH-1:0] result_tag,
    input  logic [OP_WIDTH-1:0]    result_value,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [CTRL_WIDTH-1:0]  issue_ctrl,
    output logic [OP_WIDTH-1:0]    issue_a,
    output logic [OP_WIDTH-1:0]    issue_b,
    output logic [RS_ID_WIDTH-1:0] issue_id
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    logic [RS_DEPTH-1:0]    busy_r;
    logic [RS_DEPTH-1:0]    a_rdy_r;
    logic [RS_DEPTH-1:0]    b_rdy_r;
    logic [CTRL_WIDTH-1:0]  ctrl_r  [RS_DEPTH];
    logic [OP_WIDTH-1:0]    a_val_r [RS_DEPTH];
    logic [OP_WIDTH-1:0]    b_val_r [RS_DEPTH];
    logic [RS_ID_WIDTH-1:0] a_tag_r [RS_DEPTH];
    logic [RS_ID_WIDTH-1:0] b_tag_r [RS_DEPTH];

    logic [RS_DEPTH-1:0] elig_s;
    logic [RS_DEPTH-1:0] wake_a_s;
    logic [RS_DEPTH-1:0] wake_b_s;
    logic [IDX_W-1:0]    free_idx_s;
    logic [IDX_W-1:0]    issue_idx_s;
    logic                free_found_s;
    logic                issue_found_s;
    logic                accept_s;
    logic                issue_fire_s;
    logic                bypass_a_s;
    logic                bypass_b_s;

    // Priority pick of lowest free / lowest eligible slot plus per-entry snoop matches
    always_comb begin
        elig_s      = busy_r & a_rdy_r & b_rdy_r;
        free_idx_s  = '0;
        issue_idx_s = '0;
        wake_a_s    = '0;
        wake_b_s    = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            free_idx_s  = busy_r[i] ? free_idx_s : IDX_W'(i);
            issue_idx_s = elig_s[i] ? IDX_W'(i) : issue_idx_s;
            wake_a_s[i] = busy_r[i] & ~a_rdy_r[i] & result_valid & (a_tag_r[i] == result_tag);
            wake_b_s[i] = busy_r[i] & ~b_rdy_r[i] & result_valid & (b_tag_r[i] == result_tag);
        end
    end

    assign free_found_s  = ~(&busy_r);
    assign issue_found_s = |elig_s;

    // Reset gates both handshakes so in-flight entries are dropped, never issued.
    assign operation_ready = free_found_s & ~rst;
    assign operation_id    = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(free_idx_s);
    assign issue_valid     = issue_found_s & ~rst;
    assign issue_ctrl      = ctrl_r[issue_idx_s];
    assign issue_a         = a_val_r[issue_idx_s];
    assign issue_b         = b_val_r[issue_idx_s];
    assign issue_id        = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(issue_idx_s);

    assign accept_s     = operation_valid & operation_ready;
    assign issue_fire_s = issue_valid & issue_ready;
    assign bypass_a_s   = ~op_a_valid & result_valid & (op_a_tag == result_tag);
    assign bypass_b_s   = ~op_b_valid & result_valid & (op_b_tag == result_tag);

    // Entry control state: busy and operand-ready bits
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= '0;
            a_rdy_r <= '0;
            b_rdy_r <= '0;
        end else begin
            a_rdy_r <= a_rdy_r | wake_a_s;
            b_rdy_r <= b_rdy_r | wake_b_s;
            if (issue_fire_s) begin
                busy_r[issue_idx_s] <= 1'b0;
            end
            // The allocated slot was free, so it never collides with the issuing slot.
            if (accept_s) begin
                busy_r[free_idx_s]  <= 1'b1;
                a_rdy_r[free_idx_s] <= op_a_valid | bypass_a_s;
                b_rdy_r[free_idx_s] <= op_b_valid | bypass_b_s;
            end
        end
    end

    // Entry payload: operands, tags and ctrl carry no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (wake_a_s[i]) begin
                a_val_r[i] <= result_value;
            end
            if (wake_b_s[i]) begin
                b_val_r[i] <= result_value;
            end
        end
        if (accept_s) begin
            ctrl_r[free_idx_s]  <= operation_ctrl;
            a_val_r[free_idx_s] <= op_a_valid ? op_a_value : result_value;
            b_val_r[free_idx_s] <= op_b_valid ? op_b_value : result_value;
            a_tag_r[free_idx_s] <= op_a_tag;
            b_tag_r[free_idx_s] <= op_b_tag;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with a slot-level behavioural model checked every cycle.
module tb_reservation_station;

    localparam int OFF = 0;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        operation_valid;
    logic        operation_ready;
    logic [15:0] operation_ctrl;
    logic [4:0]  operation_id;
    logic        op_a_valid, op_b_valid;
    logic [31:0] op_a_value, op_b_value;
    logic [4:0]  op_a_tag, op_b_tag;
    logic        result_valid;
    logic [4:0]  result_tag;
    logic [31:0] result_value;
    logic        issue_valid;
    logic        issue_ready;
    logic [15:0] issue_ctrl;
    logic [31:0] issue_a, issue_b;
    logic [4:0]  issue_id;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    reservation_station #(.RS_ID_WIDTH(5), .RS_OFFSET(OFF), .RS_DEPTH(DEP),
                          .OP_WIDTH(32), .CTRL_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .operation_valid(operation_valid), .operation_ready(operation_ready),
        .operation_ctrl(operation_ctrl), .operation_id(operation_id),
        .op_a_valid(op_a_valid), .op_b_valid(op_b_valid),
        .op_a_value(op_a_value), .op_b_value(op_b_value),
        .op_a_tag(op_a_tag), .op_b_tag(op_b_tag),
        .result_valid(result_valid), .result_tag(result_tag), .result_value(result_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_ctrl(issue_ctrl),
        .issue_a(issue_a), .issue_b(issue_b), .issue_id(issue_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          busy;
        logic [15:0] ctrl;
        bit          ar, br;
        logic [31:0] av, bv;
        logic [4:0]  at, bt;
    } ent_t;

    ent_t m [DEP];

    function automatic int lowest_free();
        for (int i = 0; i < DEP; i++) if (!m[i].busy) return i;
        return -1;
    endfunction

    function automatic int lowest_ready();
        for (int i = 0; i < DEP; i++) if (m[i].busy && m[i].ar && m[i].br) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply one clock edge of the station's rules
    always @(posedge clk) begin
        int f, s;
        f = lowest_free();
        s = lowest_ready();
        if (rst) begin
            for (int i = 0; i < DEP; i++) begin
                m[i].busy = 1'b0; m[i].ar = 1'b0; m[i].br = 1'b0;
            end
            started = 1'b1;
        end else begin
            if (result_valid) begin
                for (int i = 0; i < DEP; i++) begin
                    if (m[i].busy && !m[i].ar && m[i].at == result_tag) begin
                        m[i].ar = 1'b1; m[i].av = result_value;
                    end
                    if (m[i].busy && !m[i].br && m[i].bt == result_tag) begin
                        m[i].br = 1'b1; m[i].bv = result_value;
                    end
                end
            end
            if (s >= 0 && issue_ready) m[s].busy = 1'b0;
            if (operation_valid && f >= 0) begin
                m[f].busy = 1'b1;
                m[f].ctrl = operation_ctrl;
                m[f].at   = op_a_tag;
                m[f].bt   = op_b_tag;
                m[f].ar   = op_a_valid || (result_valid && op_a_tag == result_tag);
                m[f].br   = op_b_valid || (result_valid && op_b_tag == result_tag);
                m[f].av   = op_a_valid ? op_a_value : result_value;
                m[f].bv   = op_b_valid ? op_b_value : result_value;
            end
        end
    end

    // Compare DUT outputs against the model every cycle, mid-period
    always @(negedge clk) begin
        int f, s;
        if (started) begin
            f = lowest_free();
            s = lowest_ready();
            check("op_ready", {31'd0, operation_ready}, {31'd0, (!rst && f >= 0)});
            if (!rst && f >= 0) check("op_id", {27'd0, operation_id}, OFF + f);
            check("iss_valid", {31'd0, issue_valid}, {31'd0, (!rst && s >= 0)});
            if (!rst && s >= 0) begin
                check("iss_id", {27'd0, issue_id}, OFF + s);
                check("iss_ctrl", {16'd0, issue_ctrl}, {16'd0, m[s].ctrl});
                check("iss_a", issue_a, m[s].av);
                check("iss_b", issue_b, m[s].bv);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        operation_valid = 1'b0;
        result_valid    = 1'b0;
    endtask

    task automatic offer(input logic [15:0] c, input logic av, input logic [31:0] a, input logic [4:0] at,
                         input logic bv, input logic [31:0] b, input logic [4:0] bt);
        operation_valid = 1'b1; operation_ctrl = c;
        op_a_valid = av; op_a_value = a; op_a_tag = at;
        op_b_valid = bv; op_b_value = b; op_b_tag = bt;
    endtask

    task automatic bcast(input logic [4:0] t, input logic [31:0] v);
        result_valid = 1'b1; result_tag = t; result_value = v;
    endtask

    initial begin
        rst = 1'b1; issue_ready = 1'b0;
        operation_valid = 1'b0; operation_ctrl = 16'd0;
        op_a_valid = 1'b0; op_b_valid = 1'b0; op_a_value = 32'd0; op_b_value = 32'd0;
        op_a_tag = 5'd0; op_b_tag = 5'd0;
        result_valid = 1'b0; result_tag = 5'd0; result_value = 32'd0;
        cyc(); cyc();
        check("rst_iss_valid", {31'd0, issue_valid}, 32'd0);
        check("rst_op_ready", {31'd0, operation_ready}, 32'd0);
        rst = 1'b0; #1;
        check("rel_op_ready", {31'd0, operation_ready}, 32'd1);
        check("rel_op_id", {27'd0, operation_id}, OFF);

        // both operands present: issue one cycle after accept
        issue_ready = 1'b1;
        offer(16'h00AA, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
        cyc(); idle();
        check("t1_valid", {31'd0, issue_valid}, 32'd1);
        check("t1_a", issue_a, 32'd5);
        check("t1_b", issue_b, 32'd7);
        check("t1_ctrl", {16'd0, issue_ctrl}, 32'h00AA);
        check("t1_id", {27'd0, issue_id}, OFF);
        cyc();
        check("t1_drain", {31'd0, issue_valid}, 32'd0);

        // operand b waits for tag 9
        offer(16'h0011, 1'b1, 32'd3, 5'd0, 1'b0, 32'd0, 5'd9);
        cyc(); idle();
        check("t2_wait0", {31'd0, issue_valid}, 32'd0);
        cyc(); cyc(); cyc();
        bcast(5'd9, 32'h1234);
        check("t2_wait1", {31'd0, issue_valid}, 32'd0);
        cyc(); idle();
        check("t2_valid", {31'd0, issue_valid}, 32'd1);
        check("t2_b", issue_b, 32'h1234);
        check("t2_a", issue_a, 32'd3);
        cyc();

        // same-cycle bypass
        offer(16'h0022, 1'b1, 32'd1, 5'd0, 1'b0, 32'd0, 5'd9);
        bcast(5'd9, 32'hBEEF);
        cyc(); idle();
        check("t3_valid", {31'd0, issue_valid}, 32'd1);
        check("t3_b", issue_b, 32'hBEEF);
        cyc();
        check("t3_drain", {31'd0, issue_valid}, 32'd0);

        // fill every slot with an entry waiting on tag 20+i
        issue_ready = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            check("t4_fill_id", {27'd0, operation_id}, OFF + i);
            offer(16'h0030 + 16'(i), 1'b0, 32'd0, 5'(20 + i), 1'b1, 32'(i), 5'd0);
            cyc();
        end
        idle();
        check("t4_full", {31'd0, operation_ready}, 32'd0);
        bcast(5'd22, 32'h55);
        cyc(); idle();
        check("t4_wake_id", {27'd0, issue_id}, OFF + 2);
        check("t4_wake_a", issue_a, 32'h55);
        check("t4_wake_ctrl", {16'd0, issue_ctrl}, 32'h0032);
        issue_ready = 1'b1;
        cyc();
        issue_ready = 1'b0;
        check("t4_freed", {31'd0, operation_ready}, 32'd1);
        check("t4_freed_id", {27'd0, operation_id}, OFF + 2);

        // slots 3 then 1 wake; lower index takes and holds selection
        bcast(5'd23, 32'h77); cyc();
        bcast(5'd21, 32'h66); cyc(); idle();
        check("t5_sel", {27'd0, issue_id}, OFF + 1);
        check("t5_sel_a", issue_a, 32'h66);
        cyc();
        check("t5_hold1", {27'd0, issue_id}, OFF + 1);
        cyc();
        check("t5_hold2", {27'd0, issue_id}, OFF + 1);
        check("t5_hold_v", {31'd0, issue_valid}, 32'd1);
        issue_ready = 1'b1;
        cyc();
        issue_ready = 1'b0;
        check("t5_next", {27'd0, issue_id}, OFF + 3);
        check("t5_next_a", issue_a, 32'h77);

        // reset with three busy entries
        offer(16'h0040, 1'b0, 32'd0, 5'd30, 1'b1, 32'd0, 5'd0);
        cyc(); idle();
        check("t6_pre_valid", {31'd0, issue_valid}, 32'd1);
        rst = 1'b1; #1;
        check("t6_rst_valid", {31'd0, issue_valid}, 32'd0);
        check("t6_rst_ready", {31'd0, operation_ready}, 32'd0);
        cyc();
        check("t6_after_edge", {31'd0, issue_valid}, 32'd0);
        rst = 1'b0; #1;
        check("t6_rel_ready", {31'd0, operation_ready}, 32'd1);
        check("t6_rel_id", {27'd0, operation_id}, OFF);
        issue_ready = 1'b1;
        bcast(5'd20, 32'h99); cyc();
        bcast(5'd30, 32'h98); cyc(); idle();
        cyc();
        check("t6_no_stale", {31'd0, issue_valid}, 32'd0);
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
